// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: opcode encodings, error codes,
// FSM state type, default timeout and small opcode classification helpers.
package lsu_pkg;

    // Default number of stalled cycles tolerated in REQ or WAIT
    localparam int TIMEOUT_DEFAULT = 16;

    // Memory opcodes issued by the ALU stage
    localparam logic [5:0] OP_LB  = 6'b010011;
    localparam logic [5:0] OP_LH  = 6'b010100;
    localparam logic [5:0] OP_LW  = 6'b010101;
    localparam logic [5:0] OP_LBU = 6'b010110;
    localparam logic [5:0] OP_LHU = 6'b010111;
    localparam logic [5:0] OP_SB  = 6'b011000;
    localparam logic [5:0] OP_SH  = 6'b011001;
    localparam logic [5:0] OP_SW  = 6'b011010;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // True for any of the eight supported memory opcodes
    function automatic logic op_is_legal(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Halfwords must sit on an even address, words on a multiple of four
    function automatic logic op_is_misaligned(input logic [5:0] op, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = off[0];
            OP_LW, OP_SW:         r = (off != 2'b00);
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Ports:
//   store_op, store_off, store_data : request being accepted
//   store_be, store_wdata           : byte enables and lane-replicated data
//   load_op, load_off, load_word    : latched load and returned memory word
//   load_data                       : selected lane, sign- or zero-extended
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [5:0]  store_op,
    input  logic [1:0]  store_off,
    input  logic [31:0] store_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_wdata,
    input  logic [5:0]  load_op,
    input  logic [1:0]  load_off,
    input  logic [31:0] load_word,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Byte enables follow the access size; data is replicated into every lane
    // so the memory picks the right copy through the enables alone.
    always_comb begin
        store_be    = 4'b0000;
        store_wdata = store_data;
        case (store_op)
            OP_SB, OP_LB, OP_LBU: begin
                store_be    = 4'b0001 << store_off;
                store_wdata = {4{store_data[7:0]}};
            end
            OP_SH, OP_LH, OP_LHU: begin
                store_be    = 4'b0011 << store_off;
                store_wdata = {2{store_data[15:0]}};
            end
            OP_SW, OP_LW: begin
                store_be    = 4'b1111;
                store_wdata = store_data;
            end
            default: begin
                store_be    = 4'b0000;
                store_wdata = store_data;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension
    assign shifted = load_word >> {load_off, 3'b000};

    always_comb begin
        load_data = load_word;
        case (load_op)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h000000, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Runs one load or store at a time against a word-organised data memory using
// a request/grant/response handshake, and returns extended load data for
// register writeback. Misaligned, illegal and timed-out accesses are reported
// on a one-cycle error pulse.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/req_ready/req_*          : request from the ALU stage
//   mem_req/we/addr/be/wdata           : memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata     : memory grant and response
//   wb_valid, wb_rd, wb_data           : one-cycle load writeback pulse
//   err_valid, err_code, err_addr      : one-cycle error pulse
//   busy                               : an access is in flight
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr,
    output logic        busy
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    op_q;
    logic [31:0]   addr_q;
    logic [4:0]    rd_q;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;
    logic          timed_out;

    // Store steering works on the incoming request so the memory outputs can
    // be registered at accept; load extraction works on the latched request.
    lsu_lane_align u_lane_align (
        .store_op    (req_op),
        .store_off   (req_addr[1:0]),
        .store_data  (req_wdata),
        .store_be    (st_be),
        .store_wdata (st_wdata),
        .load_op     (op_q),
        .load_off    (addr_q[1:0]),
        .load_word   (mem_rdata),
        .load_data   (ld_data)
    );

    // The current cycle is the last one allowed without progress
    assign timed_out = (cnt == CNT_LAST);

    // Single FSM block: request latches, timeout counter and every registered
    // output. req_ready comes up one cycle after reset so that all outputs
    // read zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
        end else begin
            wb_valid  <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (req_valid && req_ready) begin
                        // Illegal opcode outranks misalignment
                        if (!op_is_legal(req_op)) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_ILLEGAL;
                            err_addr  <= req_addr;
                        end else if (op_is_misaligned(req_op, req_addr[1:0])) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_MISALIGN;
                            err_addr  <= req_addr;
                        end else begin
                            op_q      <= req_op;
                            addr_q    <= req_addr;
                            rd_q      <= req_rd;
                            mem_req   <= 1'b1;
                            mem_we    <= op_is_store(req_op);
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= st_be;
                            mem_wdata <= st_wdata;
                            cnt       <= '0;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WAIT;
                    end else if (timed_out) begin
                        mem_req   <= 1'b0;
                        err_valid <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        err_addr  <= addr_q;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_WAIT: begin
                    if (mem_rvalid) begin
                        // Stores finish silently; loads pulse writeback
                        if (!op_is_store(op_q)) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= ld_data;
                        end
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (timed_out) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        err_addr  <= addr_q;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    mem_req   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: a table of directed vectors, a
// randomized run against a size/offset arithmetic model, and hand-written
// sequences for timeouts and resets in the middle of an access.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    localparam logic [5:0] OP_LB  = 6'b010011;
    localparam logic [5:0] OP_LH  = 6'b010100;
    localparam logic [5:0] OP_LW  = 6'b010101;
    localparam logic [5:0] OP_LBU = 6'b010110;
    localparam logic [5:0] OP_LHU = 6'b010111;
    localparam logic [5:0] OP_SB  = 6'b011000;
    localparam logic [5:0] OP_SH  = 6'b011001;
    localparam logic [5:0] OP_SW  = 6'b011010;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gntDelay;
        int          rvDelay;
        logic [1:0]  expErr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expData;
    } vec_t;

    vec_t vectors [14];

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_addr   (err_addr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case a sequence never returns
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: derives every expected value from access size and
    // byte offset using plain arithmetic.
    function automatic vec_t buildVector(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [4:0] rd,
                                         input logic [31:0] rdata, input int gd, input int rvd);
        vec_t   v;
        int     size;
        int     off;
        bit     signedLoad;
        longint lim;
        longint field;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
        v.gntDelay = gd; v.rvDelay = rvd;
        v.expErr = 2'b00; v.expBe = 4'b0000; v.expWdata = 32'h0; v.expData = 32'h0;
        size = 0;
        signedLoad = 1'b0;
        case (op)
            OP_LB:         begin size = 1; signedLoad = 1'b1; end
            OP_LBU, OP_SB: size = 1;
            OP_LH:         begin size = 2; signedLoad = 1'b1; end
            OP_LHU, OP_SH: size = 2;
            OP_LW, OP_SW:  size = 4;
            default:       size = 0;
        endcase
        off = int'(addr[1:0]);
        if (size == 0) begin
            v.expErr = 2'b11;
        end else if (off % size != 0) begin
            v.expErr = 2'b01;
        end else begin
            v.expBe = 4'(((1 << size) - 1) << off);
            if (size == 1)      v.expWdata = {24'h0, wdata[7:0]} * 32'h01010101;
            else if (size == 2) v.expWdata = {16'h0, wdata[15:0]} * 32'h00010001;
            else                v.expWdata = wdata;
            lim   = longint'(1) << (8 * size);
            field = longint'(rdata >> (8 * off)) % lim;
            if (signedLoad && field >= lim / 2) field = field - lim;
            v.expData = field[31:0];
        end
        return v;
    endfunction

    // Issues one request from an idle unit, plays the memory side with the
    // given grant/response delays plus stray handshakes, and checks each cycle.
    // Starts and ends on a falling edge with the unit idle.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] expAddr;
        bit          isStore;
        expAddr = {v.addr[31:2], 2'b00};
        isStore = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
        checkOutput("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 6'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        if (v.expErr != 2'b00) begin
            checkOutput("err_valid", 32'(err_valid), 1);
            checkOutput("err_code", 32'(err_code), 32'(v.expErr));
            checkOutput("err_addr", err_addr, v.addr);
            checkOutput("err_no_mem_req", 32'(mem_req), 0);
            checkOutput("err_req_ready", 32'(req_ready), 1);
            checkOutput("err_no_wb", 32'(wb_valid), 0);
            @(negedge clk);
            checkOutput("err_pulse_end", 32'(err_valid), 0);
            return;
        end
        checkOutput("no_err_on_accept", 32'(err_valid), 0);
        for (int c = 0; c <= v.gntDelay; c++) begin
            checkOutput("mem_req_held", 32'(mem_req), 1);
            checkOutput("mem_addr", mem_addr, expAddr);
            checkOutput("mem_we", 32'(mem_we), 32'(isStore));
            if (isStore) begin
                checkOutput("mem_be", 32'(mem_be), 32'(v.expBe));
                checkOutput("mem_wdata", mem_wdata, v.expWdata);
            end
            checkOutput("busy_req", 32'(busy), 1);
            checkOutput("ready_low_req", 32'(req_ready), 0);
            mem_gnt    = (c == v.gntDelay);
            mem_rvalid = (c != v.gntDelay) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        for (int c = 0; c <= v.rvDelay; c++) begin
            checkOutput("mem_req_dropped", 32'(mem_req), 0);
            checkOutput("wb_idle_wait", 32'(wb_valid), 0);
            checkOutput("busy_wait", 32'(busy), 1);
            mem_rvalid = (c == v.rvDelay);
            mem_rdata  = (c == v.rvDelay) ? v.rdata : $urandom;
            mem_gnt    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        checkOutput("wb_valid", 32'(wb_valid), 32'(!isStore));
        if (!isStore) begin
            checkOutput("wb_data", wb_data, v.expData);
            checkOutput("wb_rd", 32'(wb_rd), 32'(v.rd));
        end
        checkOutput("no_err_done", 32'(err_valid), 0);
        checkOutput("ready_done", 32'(req_ready), 1);
        checkOutput("busy_done", 32'(busy), 0);
        @(negedge clk);
        checkOutput("wb_pulse_end", 32'(wb_valid), 0);
    endtask

    initial begin
        int   n;
        vec_t v;
        logic [5:0] legalOps [8];
        legalOps = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        vectors[0]  = '{OP_LW,  32'h100, 32'h0,        5'd5,  32'hDEADBEEF, 0, 0, 2'b00, 4'h0,    32'h0,        32'hDEADBEEF};
        vectors[1]  = '{OP_LB,  32'h203, 32'h0,        5'd7,  32'h80FF0000, 0, 0, 2'b00, 4'h0,    32'h0,        32'hFFFFFF80};
        vectors[2]  = '{OP_LBU, 32'h203, 32'h0,        5'd8,  32'h80FF0000, 1, 1, 2'b00, 4'h0,    32'h0,        32'h00000080};
        vectors[3]  = '{OP_SH,  32'h42,  32'h1234ABCD, 5'd9,  32'h0,        0, 0, 2'b00, 4'b1100, 32'hABCDABCD, 32'h0};
        vectors[4]  = '{OP_LW,  32'h101, 32'h0,        5'd1,  32'h0,        0, 0, 2'b01, 4'h0,    32'h0,        32'h0};
        vectors[5]  = '{6'h00,  32'h100, 32'h0,        5'd1,  32'h0,        0, 0, 2'b11, 4'h0,    32'h0,        32'h0};
        vectors[6]  = '{OP_SH,  32'h43,  32'h5555,     5'd1,  32'h0,        0, 0, 2'b01, 4'h0,    32'h0,        32'h0};
        vectors[7]  = '{6'h3F,  32'h101, 32'h0,        5'd1,  32'h0,        0, 0, 2'b11, 4'h0,    32'h0,        32'h0};
        vectors[8]  = '{OP_SB,  32'h201, 32'h000000A5, 5'd2,  32'h0,        0, 1, 2'b00, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vectors[9]  = '{OP_LH,  32'h202, 32'h0,        5'd10, 32'h80017FFF, 5, 2, 2'b00, 4'h0,    32'h0,        32'hFFFF8001};
        vectors[10] = '{OP_LHU, 32'h202, 32'h0,        5'd11, 32'h80017FFF, 2, 0, 2'b00, 4'h0,    32'h0,        32'h00008001};
        vectors[11] = '{OP_SW,  32'h300, 32'hCAFEF00D, 5'd3,  32'h0,        2, 3, 2'b00, 4'b1111, 32'hCAFEF00D, 32'h0};
        vectors[12] = '{OP_LW,  32'h104, 32'h0,        5'd0,  32'h13579BDF, 0, 0, 2'b00, 4'h0,    32'h0,        32'h13579BDF};
        vectors[13] = '{OP_LBU, 32'h001, 32'h0,        5'd31, 32'h123456F0, 0, 4, 2'b00, 4'h0,    32'h0,        32'h00000056};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 6'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Everything reads zero while reset is held
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_mem_req", 32'(mem_req), 0);
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_be", 32'(mem_be), 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_err_valid", 32'(err_valid), 0);
        checkOutput("rst_err_code", 32'(err_code), 0);
        checkOutput("rst_err_addr", err_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) applyStimulus(vectors[i]);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op;
            logic [31:0] addr;
            op = legalOps[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            v = buildVector(op, addr, $urandom, 5'($urandom), $urandom,
                            $urandom_range(0, 4), $urandom_range(0, 4));
            applyStimulus(v);
        end

        $display("[TB] grant never arrives");
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h80; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            mem_rvalid = (n == 5);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        checkOutput("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_req_err", 32'(err_valid), 1);
        checkOutput("timeout_req_code", 32'(err_code), 32'h2);
        checkOutput("timeout_req_addr", err_addr, 32'h80);
        checkOutput("timeout_req_ready", 32'(req_ready), 1);
        checkOutput("timeout_req_busy", 32'(busy), 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5A5A5;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("late_rvalid_no_wb", 32'(wb_valid), 0);
        checkOutput("late_rvalid_no_err", 32'(err_valid), 0);
        @(negedge clk);
        checkOutput("late_rvalid_still_no_wb", 32'(wb_valid), 0);

        $display("[TB] response never arrives");
        req_valid = 1'b1; req_op = OP_LH; req_addr = 32'h86; req_rd = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            mem_gnt = (n == 3);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        checkOutput("timeout_wait_cycles", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_wait_err", 32'(err_valid), 1);
        checkOutput("timeout_wait_code", 32'(err_code), 32'h2);
        checkOutput("timeout_wait_addr", err_addr, 32'h86);
        checkOutput("timeout_wait_no_wb", 32'(wb_valid), 0);
        @(negedge clk);

        $display("[TB] reset during REQ");
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h400; req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("pre_reset_mem_req", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_req_mem_req", 32'(mem_req), 0);
        checkOutput("reset_req_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset during WAIT");
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h500; req_rd = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("pre_reset_wait_busy", 32'(busy), 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_wait_mem_req", 32'(mem_req), 0);
        checkOutput("reset_wait_busy", 32'(busy), 0);
        checkOutput("reset_wait_wb", 32'(wb_valid), 0);
        @(negedge clk);
        checkOutput("reset_wait_wb_held", 32'(wb_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_late_rvalid_no_wb", 32'(wb_valid), 0);
        checkOutput("reset_late_rvalid_busy", 32'(busy), 0);
        mem_rvalid = 1'b0;
        @(negedge clk);
        applyStimulus(buildVector(OP_LW, 32'h504, 32'h0, 5'd12, 32'h76543210, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
